mult_sequencer: RTL and testbench

Control-and-datapath block that sequences the signed sequential multiplier. A single-cycle start strobe from the debounced button path latches two's-complement operands. The block then runs radix-2 Booth iterations, one per clock. It publishes a registered product with a one-cycle done pulse and a busy flag. The product feeds the display decoders, and the latched operands feed the operand LED outputs.

---
 rtl/mult_pkg.sv | 35 +++
 rtl/booth_datapath.sv | 67 ++++++
 rtl/mult_sequencer.sv | 107 ++++++++++
 tb/tb_mult_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ============================================================================
// Module : mult_pkg
// Brief  : Shared types and constants for the Booth multiplier sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit and the bit shifted out before it.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_datapath.sv
// ============================================================================
// Module : booth_datapath
// Brief  : ACC/Q/q_m1/M registers with add/sub and arithmetic right shift.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module booth_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  booth_op_t          op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               q_lsb,
    output logic               q_prev,
    output logic [2*WIDTH-1:0] prod_next
);

    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     m;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH+1:0] shifted;

    // shifted is {ACC, Q, q_m1} after the add/sub and one arithmetic right shift.
    always_comb begin
        sum = acc;
        case (op)
            ADD:     sum = acc + m;
            SUB:     sum = acc - m;
            default: sum = acc;
        endcase
        shifted = {sum[WIDTH], sum, q};
    end

    assign q_lsb     = q[0];
    assign q_prev    = q_m1;
    assign prod_next = shifted[2*WIDTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            m    <= '0;
            q    <= '0;
            q_m1 <= 1'b0;
        end else if (load) begin
            acc  <= '0;
            m    <= {a[WIDTH-1], a};
            q    <= b;
            q_m1 <= 1'b0;
        end else if (step) begin
            acc  <= shifted[2*WIDTH+1:WIDTH+1];
            q    <= shifted[WIDTH:1];
            q_m1 <= shifted[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_sequencer.sv
// ============================================================================
// Module : mult_sequencer
// Brief  : Sequences the signed Booth multiplier; registers product and status.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   a_lat,
    output logic [WIDTH-1:0]   b_lat
);

    localparam int COUNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             next_state;
    logic [COUNT_W-1:0] count;
    logic               load;
    logic               step;
    logic               last;
    booth_op_t          op;
    logic               q_lsb;
    logic               q_prev;
    logic [2*WIDTH-1:0] prod_next;

    assign op = booth_decode(q_lsb, q_prev);

    booth_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .op        (op),
        .a         (a),
        .b         (b),
        .q_lsb     (q_lsb),
        .q_prev    (q_prev),
        .prod_next (prod_next)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = (count == COUNT_W'(1));
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // busy/done are registered from next_state so they align with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            prod  <= '0;
            a_lat <= '0;
            b_lat <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (next_state == DONE);
            if (load) begin
                count <= COUNT_W'(WIDTH);
                a_lat <= a;
                b_lat <= b;
            end else if (step) begin
                count <= count - COUNT_W'(1);
            end
            if (step && last) begin
                prod <= prod_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_sequencer.sv
// ============================================================================
// Module : tb_mult_sequencer
// Brief  : Self-checking bench for mult_sequencer against a signed-product model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mult_sequencer;

    localparam int W = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] prod;
    logic [W-1:0]   a_lat;
    logic [W-1:0]   b_lat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .prod  (prod),
        .a_lat (a_lat),
        .b_lat (b_lat)
    );

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        int p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        p  = sx * sy;
        return p[2*W-1:0];
    endfunction

    // Issues one start from an IDLE cycle; returns the product seen with done, the
    // number of edges from the accepting edge (inclusive) to done, and done pulses seen.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit scribble,
                          output logic [2*W-1:0] p, output int lat, output int ndone);
        a     = xa;
        b     = xb;
        start = 1'b1;
        lat   = 0;
        ndone = 0;
        p     = '0;
        while (lat < 30 && ndone == 0) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (scribble && busy) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            if (done) begin
                ndone++;
                p = prod;
            end
        end
        @(posedge clk); #1;
        if (done) ndone++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, prod, a_lat, b_lat} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b prod=%h a_lat=%h b_lat=%h, need all zero",
                     busy, done, prod, a_lat, b_lat);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int n;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_busy: got %b need 0", busy);
        end
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_rise: busy=%b done=%b need 1/0", busy, done);
        end
        n = 1;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d need 5", n);
        end
        checks++;
        if (prod !== 8'h0F || a_lat !== 4'd3 || b_lat !== 4'd5) begin
            errors++;
            $display("FAIL basic_values: prod=%h a_lat=%h b_lat=%h need 0f/3/5", prod, a_lat, b_lat);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: done=%b busy=%b need 0/0", done, busy);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0]   ta [5] = '{4'h8, 4'h7, 4'hF, 4'h0, 4'h8};
        logic [W-1:0]   tb [5] = '{4'h8, 4'h8, 4'h1, 4'h8, 4'h7};
        logic [2*W-1:0] te [5] = '{8'h40, 8'hC8, 8'hFF, 8'h00, 8'hC8};
        logic [2*W-1:0] p;
        int lat;
        int nd;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], 1'b0, p, lat, nd);
            checks++;
            if (p !== te[i] || lat !== 5 || nd !== 1) begin
                errors++;
                $display("FAIL corner_%0d: prod=%h lat=%0d dones=%0d need %h/5/1", i, p, lat, nd, te[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [2*W-1:0] p;
        int lat;
        int nd;
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        for (int i = 0; i < 256; i++) begin
            xa = W'(i >> 4);
            xb = W'(i);
            run_op(xa, xb, 1'b1, p, lat, nd);
            checks++;
            if (p !== ref_prod(xa, xb) || nd !== 1 || lat !== 5 || a_lat !== xa || b_lat !== xb) begin
                errors++;
                $display("FAIL sweep a=%h b=%h: prod=%h dones=%0d lat=%0d a_lat=%h b_lat=%h need %h/1/5",
                         xa, xb, p, nd, lat, a_lat, b_lat, ref_prod(xa, xb));
            end
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] p;
        int lat;
        int nd;
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        for (int i = 0; i < 40; i++) begin
            xa = W'($urandom);
            xb = W'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            run_op(xa, xb, 1'b1, p, lat, nd);
            checks++;
            if (p !== ref_prod(xa, xb) || nd !== 1) begin
                errors++;
                $display("FAIL random a=%h b=%h: prod=%h dones=%0d need %h/1", xa, xb, p, nd, ref_prod(xa, xb));
            end
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int nd;
        int bad_prod;
        first = -1; second = -1; nd = 0; bad_prod = 0;
        a = 4'd2; b = 4'd3; start = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 10) start = 1'b0;
            if (cyc == 2) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            if (cyc == 4) begin
                a = 4'd2;
                b = 4'd3;
            end
            if (done) begin
                nd++;
                if (prod !== 8'h06) bad_prod++;
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        checks++;
        if (nd !== 2 || bad_prod !== 0) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d wrong_prods=%0d need 2/0", nd, bad_prod);
        end
        checks++;
        if (second - first !== 6) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d need 6", second - first);
        end
    endtask

    task automatic test_reset_abort();
        logic [2*W-1:0] p;
        int lat;
        int nd;
        a = 4'd5; b = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, prod, a_lat, b_lat} !== '0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b prod=%h a_lat=%h b_lat=%h, need all zero",
                     busy, done, prod, a_lat, b_lat);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        checks++;
        if (nd !== 0 || prod !== '0) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d prod=%h need 0/00", nd, prod);
        end
        run_op(4'hD, 4'h4, 1'b0, p, lat, nd);
        checks++;
        if (p !== 8'hF4 || nd !== 1) begin
            errors++;
            $display("FAIL abort_recover: prod=%h dones=%0d need f4/1", p, nd);
        end
    endtask

    task automatic test_hold();
        logic [2*W-1:0] p;
        int lat;
        int nd;
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        xa = W'($urandom);
        xb = W'($urandom);
        run_op(xa, xb, 1'b0, p, lat, nd);
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            checks++;
            if (prod !== ref_prod(xa, xb) || a_lat !== xa || b_lat !== xb || done !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: prod=%h a_lat=%h b_lat=%h done=%b need %h/%h/%h/0",
                         i, prod, a_lat, b_lat, done, ref_prod(xa, xb), xa, xb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_sweep();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
